// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_EN.
module icache_direct #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        ic_ready,
  input  logic        flush,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_out_addr,
  output logic        ic_flag,
  output logic [31:0] ins_addr,
  input  logic        ic_enable,
  input  logic [31:0] ins,
  input  logic        ins_rdy
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]             state;
  logic                   kill;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];

  logic [INDEX_WIDTH-1:0] f_idx;
  logic [INDEX_WIDTH-1:0] m_idx;
  logic [TAG_WIDTH-1:0]   f_tag;
  logic [TAG_WIDTH-1:0]   m_tag;
  logic                   hit;
  logic                   fill;

  always_comb begin
    f_idx = fetch_addr[INDEX_WIDTH+1:2];
    f_tag = fetch_addr[31:INDEX_WIDTH+2];
    m_idx = ins_addr[INDEX_WIDTH+1:2];
    m_tag = ins_addr[31:INDEX_WIDTH+2];
    hit   = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    fill  = rdy && (state == S_WAIT) && ins_rdy;
  end

  assign ic_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      kill         <= 1'b0;
      valid        <= '0;
      ins_valid    <= 1'b0;
      ins_out      <= '0;
      ins_out_addr <= '0;
      ic_flag      <= 1'b0;
      ins_addr     <= '0;
    end else if (rdy) begin
      ins_valid <= 1'b0;
      ic_flag   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_valid && !flush) begin
            if (hit) begin
              ins_out      <= data_mem[f_idx];
              ins_out_addr <= fetch_addr;
              ins_valid    <= 1'b1;
            end else begin
              ins_addr <= fetch_addr;
              kill     <= 1'b0;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A flush here still issues the request so the controller sees a full handshake.
          if (flush) kill <= 1'b1;
          if (ic_enable) begin
            ic_flag <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) kill <= 1'b1;
          if (ins_rdy) begin
            valid[m_idx] <= 1'b1;
            if (!kill && !flush) begin
              ins_out      <= ins;
              ins_out_addr <= ins_addr;
              ins_valid    <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data need no reset: the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[m_idx]  <= m_tag;
      data_mem[m_idx] <= ins;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy && (state == S_IDLE) && fetch_valid && !flush) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct; inputs driven 1 time unit after each rising edge.
// Counter checks are compiled in when ICACHE_PERF_EN is defined.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_valid, flush, ic_enable, ins_rdy;
  logic [31:0] fetch_addr, ins;
  logic        ic_ready, ins_valid, ic_flag;
  logic [31:0] ins_out, ins_out_addr, ins_addr;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icache_direct #(.INDEX_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .ic_ready(ic_ready),
    .flush(flush), .ins_valid(ins_valid), .ins_out(ins_out), .ins_out_addr(ins_out_addr),
    .ic_flag(ic_flag), .ins_addr(ins_addr), .ic_enable(ic_enable),
    .ins(ins), .ins_rdy(ins_rdy)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full miss: one flag pulse over a 6-cycle wait, then fill and delivery.
  task automatic miss(input string tg, input logic [31:0] a, input logic [31:0] w);
    int flags;
    fetch_valid = 1'b1; fetch_addr = a;
    tick();
    fetch_valid = 1'b0;
    check({tg, "_busy"}, {31'd0, ic_ready}, 32'd0);
    flags = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ic_flag) flags++;
    end
    check({tg, "_flags"}, flags, 32'd1);
    check({tg, "_maddr"}, ins_addr, a);
    ins = w; ins_rdy = 1'b1;
    tick();
    ins_rdy = 1'b0;
    check({tg, "_vld"}, {31'd0, ins_valid}, 32'd1);
    check({tg, "_data"}, ins_out, w);
    check({tg, "_addr"}, ins_out_addr, a);
    tick();
    check({tg, "_vld0"}, {31'd0, ins_valid}, 32'd0);
  endtask

  task automatic hit(input string tg, input logic [31:0] a, input logic [31:0] w);
    fetch_valid = 1'b1; fetch_addr = a;
    tick();
    fetch_valid = 1'b0;
    check({tg, "_vld"}, {31'd0, ins_valid}, 32'd1);
    check({tg, "_data"}, ins_out, w);
    check({tg, "_flag"}, {31'd0, ic_flag}, 32'd0);
    check({tg, "_rdy"}, {31'd0, ic_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; flush = 1'b0;
    ic_enable = 1'b1; ins = '0; ins_rdy = 1'b0;
    tick(); tick();
    check("rst_ready", {31'd0, ic_ready}, 32'd1);
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_flag", {31'd0, ic_flag}, 32'd0);
    check("rst_out", ins_out, 32'd0);
    check("rst_oaddr", ins_out_addr, 32'd0);
    check("rst_maddr", ins_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Cold miss, then hits including 4 back-to-back
    miss("m0", 32'h0000_0000, 32'h0000_0013);
    hit("h0", 32'h0000_0000, 32'h0000_0013);
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b2b_vld", {31'd0, ins_valid}, 32'd1);
      check("b2b_data", ins_out, 32'h0000_0013);
    end
    fetch_valid = 1'b0;
    tick();
    check("b2b_end", {31'd0, ins_valid}, 32'd0);

    // Conflict on index 0
    miss("m100", 32'h0000_0100, 32'hDEAD_BEEF);
    miss("m0b", 32'h0000_0000, 32'h0000_0013);
    hit("h0b", 32'h0000_0000, 32'h0000_0013);

    // Flush in IDLE drops the fetch
    flush = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'h0;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    check("fl_idle_vld", {31'd0, ins_valid}, 32'd0);
    check("fl_idle_rdy", {31'd0, ic_ready}, 32'd1);

    // ic_enable held low in REQ
    fetch_valid = 1'b1; fetch_addr = 32'h0000_0040; ic_enable = 1'b0;
    tick();
    fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_hold_flag", {31'd0, ic_flag}, 32'd0);
      check("en_hold_busy", {31'd0, ic_ready}, 32'd0);
    end
    ic_enable = 1'b1;
    tick();
    check("en_flag", {31'd0, ic_flag}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_flag0", {31'd0, ic_flag}, 32'd0);
      check("en_maddr", ins_addr, 32'h0000_0040);
    end
    ins = 32'hCAFE_F00D; ins_rdy = 1'b1;
    tick();
    ins_rdy = 1'b0;
    check("en_vld", {31'd0, ins_valid}, 32'd1);
    check("en_data", ins_out, 32'hCAFE_F00D);
    tick();

    // Flush two cycles after the flag: fill written, delivery suppressed
    fetch_valid = 1'b1; fetch_addr = 32'h0000_0080;
    tick();
    fetch_valid = 1'b0;
    tick();
    check("fl_flag", {31'd0, ic_flag}, 32'd1);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    ins = 32'h1234_5678; ins_rdy = 1'b1;
    tick();
    ins_rdy = 1'b0;
    check("fl_vld", {31'd0, ins_valid}, 32'd0);
    check("fl_idle", {31'd0, ic_ready}, 32'd1);
    hit("fl_hit", 32'h0000_0080, 32'h1234_5678);

    // Flush coincident with ins_rdy
    fetch_valid = 1'b1; fetch_addr = 32'h0000_00C0;
    tick();
    fetch_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    ins = 32'hA5A5_0001; ins_rdy = 1'b1; flush = 1'b1;
    tick();
    ins_rdy = 1'b0; flush = 1'b0;
    check("flc_vld", {31'd0, ins_valid}, 32'd0);
    hit("flc_hit", 32'h0000_00C0, 32'hA5A5_0001);

    // Freeze during WAIT while ic_flag is high, then async reset mid-WAIT
    fetch_valid = 1'b1; fetch_addr = 32'h0000_0200;
    tick();
    fetch_valid = 1'b0;
    tick();
    check("frz_flag", {31'd0, ic_flag}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_flag_hold", {31'd0, ic_flag}, 32'd1);
      check("frz_busy", {31'd0, ic_ready}, 32'd0);
      check("frz_maddr", ins_addr, 32'h0000_0200);
    end
    rdy = 1'b1;
    tick();
    check("frz_flag_drop", {31'd0, ic_flag}, 32'd0);
    check("frz_still_wait", {31'd0, ic_ready}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", {31'd0, ic_ready}, 32'd1);
    check("arst_maddr", ins_addr, 32'd0);
    check("arst_out", ins_out, 32'd0);
    check("arst_oaddr", ins_out_addr, 32'd0);
    tick();
    rst = 1'b1;
    ins = 32'hBAD0_BAD0; ins_rdy = 1'b1;
    tick();
    ins_rdy = 1'b0;
    check("late_rdy_vld", {31'd0, ins_valid}, 32'd0);
    check("late_rdy_idle", {31'd0, ic_ready}, 32'd1);

    // Valid bits cleared: all of these miss, then hit
    miss("pm0", 32'h0000_0200, 32'h1111_0000);
    miss("pm1", 32'h0000_0204, 32'h1111_0004);
    miss("pm2", 32'h0000_0208, 32'h1111_0008);
    hit("ph0", 32'h0000_0200, 32'h1111_0000);
    hit("ph1", 32'h0000_0204, 32'h1111_0004);
    hit("ph2", 32'h0000_0208, 32'h1111_0008);
    hit("ph3", 32'h0000_0200, 32'h1111_0000);
    hit("ph4", 32'h0000_0208, 32'h1111_0008);
`ifdef ICACHE_PERF_EN
    check("miss_cnt", miss_cnt, 32'd3);
    check("hit_cnt", hit_cnt, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
